mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter DATA_PRIO, default 1, meaning: 1 = data side wins simultaneous requests, 0 = instruction side wins.
REQ-002 SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-003 SHALL have port resetn  input  1  asynchronous active-low reset.
REQ-004 SHALL have instruction-side ports: inst_req in 1; inst_wr in 1; inst_size in 2; inst_addr in 32; inst_wdata in 32; inst_addr_ok out 1; inst_data_ok out 1; inst_rdata out 32.
REQ-005 SHALL have data-side ports: data_req in 1; data_wr in 1; data_size in 2; data_addr in 32; data_wdata in 32; data_addr_ok out 1; data_data_ok out 1; data_rdata out 32.
REQ-006 SHALL have memory-side ports: mem_req out 1; mem_wr out 1; mem_size out 2; mem_addr out 32; mem_wdata out 32; mem_addr_ok in 1; mem_data_ok in 1; mem_rdata in 32.
REQ-007 SHALL have port flush  input  1  pipeline flush (exception/ertn); cancels the in-flight instruction-side transaction.

Function
REQ-008 SHALL share one sram-like memory port between the two requesters, with at most one outstanding transaction.
REQ-009 SHALL implement states IDLE, ADDR, DATA.
REQ-010 In IDLE, with any request asserted, SHALL register the winner (grant: 0 = inst, 1 = data) and latch its wr/size/addr/wdata, then move to ADDR next cycle.
REQ-011 On simultaneous inst_req and data_req in IDLE, SHALL grant data if DATA_PRIO=1, else inst.
REQ-012 In ADDR, SHALL drive mem_req=1 and mem_wr/size/addr/wdata from the latched registers, independent of current requester inputs.
REQ-013 In ADDR, when mem_addr_ok=1, SHALL pulse the granted side's addr_ok for that same cycle and move to DATA.
REQ-014 In DATA, SHALL drive mem_req=0; on mem_data_ok=1, SHALL pulse the granted side's data_ok, drive its rdata=mem_rdata in that cycle, and return to IDLE.
REQ-015 SHALL keep addr_ok/data_ok of the non-granted side at 0 at all times.
REQ-016 SHALL drive every rdata output to mem_rdata when its data_ok is 1, and to 0 otherwise.
REQ-017 Minimum latency, request to addr_ok: 1 cycle (IDLE->ADDR, mem_addr_ok already 1).
REQ-018 After data_ok, SHALL spend one cycle in IDLE before the next grant; no back-to-back issue.
REQ-019 SHALL set a cancel flag when flush=1 while grant=inst and state is ADDR or DATA.
REQ-020 A cancelled transaction SHALL still complete on the memory side: mem_req held until mem_addr_ok, then mem_data_ok awaited.
REQ-021 SHALL suppress inst_addr_ok and inst_data_ok of a cancelled transaction, including a flush in the same cycle as mem_addr_ok/mem_data_ok.
REQ-022 SHALL clear the cancel flag on return to IDLE.
REQ-023 flush in IDLE SHALL have no effect.
REQ-024 flush SHALL never cancel a data-side transaction.
REQ-025 In IDLE, SHALL ignore mem_addr_ok and mem_data_ok, producing no side effects.

Reset
REQ-026 While resetn=0, SHALL force state=IDLE, grant=0, cancel=0, and latched fields to 0, independent of clk.
REQ-027 While resetn=0, SHALL drive mem_req, all addr_ok/data_ok, and all rdata to 0.
REQ-028 Reset asserted mid-transaction SHALL abandon that transaction with no ok pulse delivered.
REQ-029 After resetn rises, the first grant SHALL be possible on the first clk edge.

Verification
REQ-030 inst_req, addr=0x1c000000, mem_addr_ok=1 immediately, mem_data_ok 2 cycles later with rdata=0x02800c0c -> inst_addr_ok at cycle 1, inst_data_ok with inst_rdata=0x02800c0c, data side silent.
REQ-031 inst_req and data_req (wr=1, addr=0x1c000100, wdata=0xdeadbeef) together, DATA_PRIO=1 -> data granted first with mem_wr=1 and mem_addr=0x1c000100; inst issued after data_data_ok plus one IDLE cycle.
REQ-032 inst granted with mem_addr_ok held low 3 cycles while inst_req drops and inst_addr changes -> mem_req stays 1 and mem_addr stays at the latched value until addr_ok.
REQ-033 flush pulse in DATA with grant=inst -> mem_data_ok consumed, inst_data_ok stays 0, next inst request granted normally.
REQ-034 flush in same cycle as mem_addr_ok for inst -> inst_addr_ok=0, transaction completes silently; flush during data transaction -> data_data_ok still pulses.
REQ-035 resetn low in ADDR state -> mem_req=0 asynchronously, no ok pulses, state IDLE after release.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one sram-like memory port between an instruction
// requester and a data requester. One outstanding transaction at a time;
// request fields are latched at grant so the memory side sees stable values
// regardless of what the requester does afterwards.
module mem_port_arbiter #(
  parameter bit DATA_PRIO = 1'b1
) (
  input  logic        clk,
  input  logic        resetn,

  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,

  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,

  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata,

  input  logic        flush
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic        grant_q;   // 0 = inst, 1 = data
  logic        cancel_q;
  logic        lat_wr;
  logic [1:0]  lat_size;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;

  logic        any_req;
  logic        grant_win;
  logic        addr_hs;
  logic        data_hs;
  logic        inst_ok_en;

  assign any_req   = inst_req | data_req;
  assign grant_win = data_req & (DATA_PRIO | ~inst_req);

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: one address phase, one data phase, then back to IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_req)     state_d = ADDR;
      ADDR:    if (mem_addr_ok) state_d = DATA;
      DATA:    if (mem_data_ok) state_d = IDLE;
      default:                  state_d = IDLE;
    endcase
  end

  // Grant, latched request fields and instruction-side cancel flag
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      grant_q   <= 1'b0;
      cancel_q  <= 1'b0;
      lat_wr    <= 1'b0;
      lat_size  <= '0;
      lat_addr  <= '0;
      lat_wdata <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          cancel_q <= 1'b0;
          if (any_req) begin
            grant_q   <= grant_win;
            lat_wr    <= grant_win ? data_wr    : inst_wr;
            lat_size  <= grant_win ? data_size  : inst_size;
            lat_addr  <= grant_win ? data_addr  : inst_addr;
            lat_wdata <= grant_win ? data_wdata : inst_wdata;
          end
        end
        ADDR: begin
          if (flush && !grant_q) cancel_q <= 1'b1;
        end
        DATA: begin
          // Completion wins over a same-cycle flush: the flag must not
          // leak into the next transaction.
          if (mem_data_ok)            cancel_q <= 1'b0;
          else if (flush && !grant_q) cancel_q <= 1'b1;
        end
        default: cancel_q <= 1'b0;
      endcase
    end
  end

  // Memory-side drive and per-side handshake decode
  always_comb begin
    mem_req      = (state_q == ADDR);
    mem_wr       = lat_wr;
    mem_size     = lat_size;
    mem_addr     = lat_addr;
    mem_wdata    = lat_wdata;

    addr_hs      = mem_req & mem_addr_ok;
    data_hs      = (state_q == DATA) & mem_data_ok;
    // A flush arriving in the handshake cycle itself must also suppress.
    inst_ok_en   = ~grant_q & ~cancel_q & ~flush;

    inst_addr_ok = addr_hs & inst_ok_en;
    inst_data_ok = data_hs & inst_ok_en;
    data_addr_ok = addr_hs & grant_q;
    data_data_ok = data_hs & grant_q;

    inst_rdata   = inst_data_ok ? mem_rdata : '0;
    data_rdata   = data_data_ok ? mem_rdata : '0;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scenarios with literal expectations plus a
// randomized run, all compared against a transaction-level model of the
// arbiter held in the bench.
module tb_mem_port_arbiter;

  localparam bit PRIO = 1'b1;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_req, inst_wr, data_req, data_wr;
  logic [1:0]  inst_size, data_size;
  logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [31:0] inst_rdata, data_rdata;
  logic        mem_req, mem_wr;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_addr_ok, mem_data_ok, flush;

  mem_port_arbiter #(.DATA_PRIO(PRIO)) dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
    .inst_addr(inst_addr), .inst_wdata(inst_wdata),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata),
    .flush(flush)
  );

  always #5 clk = ~clk;

  int unsigned n_total = 0;
  int unsigned n_pass  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    else
      n_pass++;
  endtask

  // Transaction-level model: one optional outstanding transaction record.
  bit          m_busy, m_issued, m_side, m_cancel, m_wr;
  bit [1:0]    m_size;
  bit [31:0]   m_addr, m_wdata;
  // Staged next values, applied at the clock edge
  bit          n_busy, n_issued, n_side, n_cancel, n_wr;
  bit [1:0]    n_size;
  bit [31:0]   n_addr, n_wdata;

  task automatic model_clear();
    m_busy = 0; m_issued = 0; m_side = 0; m_cancel = 0;
    m_wr = 0; m_size = '0; m_addr = '0; m_wdata = '0;
  endtask

  // Compare DUT outputs with the model for the current inputs and stage the
  // model's next state.
  task automatic settle();
    bit e_mreq, e_iao, e_ido, e_dao, e_ddo, inst_quiet;
    #1;
    if (!resetn) model_clear();
    inst_quiet = m_cancel || flush;
    e_mreq = m_busy && !m_issued;
    e_iao  = e_mreq && mem_addr_ok && !m_side && !inst_quiet;
    e_dao  = e_mreq && mem_addr_ok && m_side;
    e_ido  = m_busy && m_issued && mem_data_ok && !m_side && !inst_quiet;
    e_ddo  = m_busy && m_issued && mem_data_ok && m_side;
    chk("mem_req",      {31'd0, mem_req},      {31'd0, e_mreq});
    chk("inst_addr_ok", {31'd0, inst_addr_ok}, {31'd0, e_iao});
    chk("inst_data_ok", {31'd0, inst_data_ok}, {31'd0, e_ido});
    chk("data_addr_ok", {31'd0, data_addr_ok}, {31'd0, e_dao});
    chk("data_data_ok", {31'd0, data_data_ok}, {31'd0, e_ddo});
    chk("inst_rdata",   inst_rdata, e_ido ? mem_rdata : 32'd0);
    chk("data_rdata",   data_rdata, e_ddo ? mem_rdata : 32'd0);
    if (e_mreq) begin
      chk("mem_wr",    {31'd0, mem_wr},   {31'd0, m_wr});
      chk("mem_size",  {30'd0, mem_size}, {30'd0, m_size});
      chk("mem_addr",  mem_addr,  m_addr);
      chk("mem_wdata", mem_wdata, m_wdata);
    end
    n_busy = m_busy; n_issued = m_issued; n_side = m_side; n_cancel = m_cancel;
    n_wr = m_wr; n_size = m_size; n_addr = m_addr; n_wdata = m_wdata;
    if (!m_busy) begin
      if (inst_req || data_req) begin
        n_busy = 1; n_issued = 0; n_cancel = 0;
        n_side = data_req && (PRIO || !inst_req);
        n_wr    = n_side ? data_wr    : inst_wr;
        n_size  = n_side ? data_size  : inst_size;
        n_addr  = n_side ? data_addr  : inst_addr;
        n_wdata = n_side ? data_wdata : inst_wdata;
      end
    end else begin
      if (flush && !m_side) n_cancel = 1;
      if (!m_issued) begin
        if (mem_addr_ok) n_issued = 1;
      end else if (mem_data_ok) begin
        n_busy = 0; n_issued = 0; n_cancel = 0;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (resetn) begin
      m_busy = n_busy; m_issued = n_issued; m_side = n_side; m_cancel = n_cancel;
      m_wr = n_wr; m_size = n_size; m_addr = n_addr; m_wdata = n_wdata;
    end else begin
      model_clear();
    end
    @(negedge clk);
  endtask

  task automatic quiet();
    inst_req = 0; inst_wr = 0; inst_size = '0; inst_addr = '0; inst_wdata = '0;
    data_req = 0; data_wr = 0; data_size = '0; data_addr = '0; data_wdata = '0;
    mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = '0; flush = 0;
  endtask

  task automatic do_reset();
    resetn = 0;
    settle(); tick();
    settle(); tick();
    resetn = 1;
  endtask

  initial begin
    quiet();
    resetn = 0;
    model_clear();
    @(negedge clk);
    settle();
    chk("reset_mem_req", {31'd0, mem_req}, 32'd0);
    tick();
    do_reset();

    // Instruction fetch with immediate address accept
    inst_req = 1; inst_addr = 32'h1c000000; inst_size = 2'd2; mem_addr_ok = 1;
    settle(); chk("t30_idle_mem_req", {31'd0, mem_req}, 32'd0); tick();
    inst_req = 0; inst_addr = 32'h0;
    settle();
    chk("t30_inst_addr_ok", {31'd0, inst_addr_ok}, 32'd1);
    chk("t30_mem_addr", mem_addr, 32'h1c000000);
    tick();
    mem_addr_ok = 0;
    settle(); tick();
    mem_data_ok = 1; mem_rdata = 32'h02800c0c;
    settle();
    chk("t30_inst_data_ok", {31'd0, inst_data_ok}, 32'd1);
    chk("t30_inst_rdata", inst_rdata, 32'h02800c0c);
    chk("t30_data_silent", {31'd0, data_data_ok}, 32'd0);
    tick();
    quiet();

    // Simultaneous requests: data side first, inst after one idle cycle
    inst_req = 1; inst_addr = 32'h1c000200;
    data_req = 1; data_wr = 1; data_addr = 32'h1c000100; data_wdata = 32'hdeadbeef;
    settle(); tick();
    data_req = 0; mem_addr_ok = 1;
    settle();
    chk("t31_mem_wr", {31'd0, mem_wr}, 32'd1);
    chk("t31_mem_addr", mem_addr, 32'h1c000100);
    chk("t31_mem_wdata", mem_wdata, 32'hdeadbeef);
    chk("t31_data_addr_ok", {31'd0, data_addr_ok}, 32'd1);
    chk("t31_inst_addr_ok", {31'd0, inst_addr_ok}, 32'd0);
    tick();
    mem_addr_ok = 0; mem_data_ok = 1; mem_rdata = 32'h11223344;
    settle(); chk("t31_data_data_ok", {31'd0, data_data_ok}, 32'd1); tick();
    mem_data_ok = 0;
    settle(); chk("t31_idle_gap", {31'd0, mem_req}, 32'd0); tick();
    inst_req = 0; mem_addr_ok = 1;
    settle();
    chk("t31_inst_mem_addr", mem_addr, 32'h1c000200);
    chk("t31_inst_addr_ok", {31'd0, inst_addr_ok}, 32'd1);
    tick();
    mem_addr_ok = 0; mem_data_ok = 1;
    settle(); tick();
    quiet();

    // Address stall with requester inputs changing underneath
    inst_req = 1; inst_addr = 32'h1c000040;
    settle(); tick();
    for (int unsigned i = 0; i < 3; i++) begin
      inst_req = 0; inst_addr = 32'hffff0000 + i;
      settle();
      chk("t32_mem_req", {31'd0, mem_req}, 32'd1);
      chk("t32_mem_addr", mem_addr, 32'h1c000040);
      tick();
    end
    mem_addr_ok = 1;
    settle(); chk("t32_addr_ok", {31'd0, inst_addr_ok}, 32'd1); tick();
    mem_addr_ok = 0;
    // Flush while waiting for data: completion must be silent
    flush = 1;
    settle(); tick();
    flush = 0; mem_data_ok = 1;
    settle(); chk("t33_inst_data_ok", {31'd0, inst_data_ok}, 32'd0); tick();
    mem_data_ok = 0; inst_req = 1; inst_addr = 32'h1c000080;
    settle(); tick();
    inst_req = 0; mem_addr_ok = 1;
    settle(); chk("t33_regrant_addr_ok", {31'd0, inst_addr_ok}, 32'd1); tick();
    mem_addr_ok = 0; mem_data_ok = 1;
    settle(); chk("t33_regrant_data_ok", {31'd0, inst_data_ok}, 32'd1); tick();
    quiet();

    // Flush coincident with address accept; then flush on a data transaction
    inst_req = 1; inst_addr = 32'h1c0000c0;
    settle(); tick();
    inst_req = 0; mem_addr_ok = 1; flush = 1;
    settle(); chk("t34_inst_addr_ok", {31'd0, inst_addr_ok}, 32'd0); tick();
    mem_addr_ok = 0; flush = 0; mem_data_ok = 1;
    settle(); chk("t34_inst_data_ok", {31'd0, inst_data_ok}, 32'd0); tick();
    mem_data_ok = 0; data_req = 1; data_addr = 32'h1c000300;
    settle(); tick();
    data_req = 0; flush = 1; mem_addr_ok = 1;
    settle(); chk("t34_data_addr_ok", {31'd0, data_addr_ok}, 32'd1); tick();
    mem_addr_ok = 0; mem_data_ok = 1; mem_rdata = 32'hcafef00d;
    settle();
    chk("t34_data_data_ok", {31'd0, data_data_ok}, 32'd1);
    chk("t34_data_rdata", data_rdata, 32'hcafef00d);
    tick();
    quiet();

    // Asynchronous reset while in the address phase
    inst_req = 1; inst_addr = 32'h1c000400;
    settle(); tick();
    inst_req = 0;
    settle();
    chk("t35_pre_mem_req", {31'd0, mem_req}, 32'd1);
    #1 resetn = 0; mem_addr_ok = 1;
    #1;
    chk("t35_async_mem_req", {31'd0, mem_req}, 32'd0);
    chk("t35_async_addr_ok", {31'd0, inst_addr_ok}, 32'd0);
    tick();
    resetn = 1; mem_addr_ok = 1; mem_data_ok = 1;
    settle();
    chk("t35_post_mem_req", {31'd0, mem_req}, 32'd0);
    chk("t35_post_data_ok", {31'd0, inst_data_ok}, 32'd0);
    tick();
    quiet();

    // Randomized traffic
    for (int unsigned c = 0; c < 4000; c++) begin
      resetn      = ($urandom_range(0, 299) != 0);
      inst_req    = ($urandom_range(0, 9) < 4);
      data_req    = ($urandom_range(0, 9) < 4);
      inst_wr     = $urandom_range(0, 1);
      data_wr     = $urandom_range(0, 1);
      inst_size   = 2'($urandom_range(0, 3));
      data_size   = 2'($urandom_range(0, 3));
      inst_addr   = $urandom;
      data_addr   = $urandom;
      inst_wdata  = $urandom;
      data_wdata  = $urandom;
      mem_addr_ok = $urandom_range(0, 1);
      mem_data_ok = $urandom_range(0, 1);
      mem_rdata   = $urandom;
      flush       = ($urandom_range(0, 9) == 0);
      settle();
      tick();
    end
    resetn = 1;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
